alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters, e.g. the main execute path and a
//  helper unit such as an address generator. Each cycle it arbitrates round-robin and
//  drives the winner's operands and op code onto the ALU. It captures ALUResult and the
//  Zero/N/C/V flags into a per-requester response register. Requests and responses use a
//  valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH      32  operand/result width
//  ALU_CTRL_WIDTH  4   ALUControl width (encoding as in ALU: 0000 add, 0001 sub, ...)
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               asynchronous reset, active low
//  Req0Valid    in   1               requester 0 has an op
//  Req0Ready    out  1               requester 0 op accepted this cycle
//  Req0SrcA     in   DATA_WIDTH      requester 0 operand A
//  Req0SrcB     in   DATA_WIDTH      requester 0 operand B
//  Req0Ctrl     in   ALU_CTRL_WIDTH  requester 0 ALU op
//  Req1Valid/Req1Ready/Req1SrcA/Req1SrcB/Req1Ctrl   same as requester 0
//  Resp0Valid   out  1               response 0 register holds a result
//  Resp0Ready   in   1               consumer 0 takes the result
//  Resp0Result  out  DATA_WIDTH      captured ALUResult
//  Resp0Flags   out  4               captured {Zero,N,C,V}
//  Resp1Valid/Resp1Ready/Resp1Result/Resp1Flags     same as response 0
//  AluSrcA      out  DATA_WIDTH      to ALU SrcA
//  AluSrcB      out  DATA_WIDTH      to ALU SrcB
//  AluControl   out  ALU_CTRL_WIDTH  to ALU ALUControl
//  AluResult    in   DATA_WIDTH      from ALU
//  AluZero, AluN, AluC, AluV  in 1 each  ALU flags
//  LastGrant    out  1               index of most recently granted requester
// BEHAVIOUR
//  - Reset: Resp*Valid=0, Resp*Result=0, Resp*Flags=0, LastGrant=1 (requester 0 first).
//    While rst_n=0, Req*Ready=0 and the ALU outputs are 0.
//  - Eligibility: elig[i] = ReqiValid && (!RespiValid || RespiReady). A full response slot
//    that is not draining blocks only its own requester.
//  - Grant (combinational, at most one per cycle): if both are eligible, grant the index
//    != LastGrant. Otherwise grant the single eligible one. Otherwise grant none.
//    ReqiReady = grant[i]. LastGrant updates to i on a clock edge with grant[i]; it holds
//    otherwise.
//  - ALU drive: the winner's SrcA/SrcB/Ctrl go straight to the ALU outputs. With no grant,
//    the outputs are 0 (add 0+0). The ALU is combinational; the result is sampled at the
//    same edge.
//  - Latency: accept at edge N gives RespiValid=1 after edge N, with Result/Flags of that
//    op. Throughput is 1 op/cycle total.
//  - Response register i, per edge:
//      grant[i]                 -> load result/flags, Valid=1. This covers simultaneous
//                                  drain+refill: Valid stays 1 and the data is replaced.
//      !grant[i] && RespiReady  -> Valid=0, data held.
//      otherwise                -> hold.
//  - Flags are captured unmodified. C is meaningful only for add/sub, V only for add; the
//    consumer ignores them for other ops.
//  - Requester fields may change while Valid && !Ready; only the granted cycle's values
//    are used.
//  - Reset asserted mid-operation discards every held result; no response is produced for
//    ops accepted before reset.
//  - Fairness: with both requesters continuously eligible, grants strictly alternate.
//    Neither waits more than 1 cycle when its slot is free.
// TESTING
//  1. Reset with traffic in flight (Resp0Valid=1) -> Resp0Valid=Resp1Valid=0, Results=0,
//     LastGrant=1; Req*Ready=0 while rst_n=0.
//  2. Req0 only: SrcA=5, SrcB=7, Ctrl=0000, Resp0Ready=1 -> Req0Ready=1 that cycle; next
//     cycle Resp0Valid=1, Result=12, Flags=4'b0000.
//  3. Req0 sub 3-3 (Ctrl=0001) -> Resp0Result=0, Flags=4'b1000 (Zero=1).
//  4. Both valid for 6 cycles, both Resp*Ready=1 -> grants 0,1,0,1,0,1; each result lands
//     in its own slot.
//  5. Resp0Valid=1, Resp0Ready=0, both requesting for 4 cycles -> req1 granted every
//     cycle, Req0Ready=0, Resp0Result unchanged. Raising Resp0Ready lets req0 be granted
//     next.
//  6. Resp0Valid=1, Resp0Ready=1 and a new Req0 accepted (0xFFFFFFFF+1, add) -> Resp0Valid
//     stays 1, Result=0, Flags=4'b1010 (Zero=1, C=1).

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between
// two valid/ready requesters, with a registered response slot per requester.
//
// Ports:
//   clk, rst_n                 clock (rising), async active-low reset
//   Req{0,1}Valid/Ready        request handshake
//   Req{0,1}SrcA/SrcB/Ctrl     request operands and ALU op
//   Resp{0,1}Valid/Ready       response handshake
//   Resp{0,1}Result/Flags      captured ALUResult and {Zero,N,C,V}
//   AluSrcA/SrcB/Control       drive to the shared ALU
//   AluResult, AluZero/N/C/V   combinational ALU return
//   LastGrant                  most recently granted requester
module alu_share_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      Req0Valid,
    output logic                      Req0Ready,
    input  logic [DATA_WIDTH-1:0]     Req0SrcA,
    input  logic [DATA_WIDTH-1:0]     Req0SrcB,
    input  logic [ALU_CTRL_WIDTH-1:0] Req0Ctrl,

    input  logic                      Req1Valid,
    output logic                      Req1Ready,
    input  logic [DATA_WIDTH-1:0]     Req1SrcA,
    input  logic [DATA_WIDTH-1:0]     Req1SrcB,
    input  logic [ALU_CTRL_WIDTH-1:0] Req1Ctrl,

    output logic                      Resp0Valid,
    input  logic                      Resp0Ready,
    output logic [DATA_WIDTH-1:0]     Resp0Result,
    output logic [3:0]                Resp0Flags,

    output logic                      Resp1Valid,
    input  logic                      Resp1Ready,
    output logic [DATA_WIDTH-1:0]     Resp1Result,
    output logic [3:0]                Resp1Flags,

    output logic [DATA_WIDTH-1:0]     AluSrcA,
    output logic [DATA_WIDTH-1:0]     AluSrcB,
    output logic [ALU_CTRL_WIDTH-1:0] AluControl,
    input  logic [DATA_WIDTH-1:0]     AluResult,
    input  logic                      AluZero,
    input  logic                      AluN,
    input  logic                      AluC,
    input  logic                      AluV,

    output logic                      LastGrant
);

    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;
    logic       last_grant;
    logic [3:0] alu_flags;

    // A full slot only blocks its own requester, and only
    // when it is not being drained this cycle.
    assign elig0 = Req0Valid && (!Resp0Valid || Resp0Ready);
    assign elig1 = Req1Valid && (!Resp1Valid || Resp1Ready);

    assign alu_flags = {AluZero, AluN, AluC, AluV};
    assign LastGrant = last_grant;
    assign Req0Ready = grant0;
    assign Req1Ready = grant1;

    // No grants while reset is held, so nothing is accepted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            unique case ({elig0, elig1})
                2'b11: begin
                    grant0 = last_grant;
                    grant1 = !last_grant;
                end
                2'b10:   grant0 = 1'b1;
                2'b01:   grant1 = 1'b1;
                default: ;
            endcase
        end
    end

    // Idle ALU sees add 0+0.
    always_comb begin
        AluSrcA    = '0;
        AluSrcB    = '0;
        AluControl = '0;
        if (grant0) begin
            AluSrcA    = Req0SrcA;
            AluSrcB    = Req0SrcB;
            AluControl = Req0Ctrl;
        end else if (grant1) begin
            AluSrcA    = Req1SrcA;
            AluSrcB    = Req1SrcB;
            AluControl = Req1Ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // A grant wins over a drain, so drain+refill keeps Valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Resp0Valid  <= 1'b0;
            Resp0Result <= '0;
            Resp0Flags  <= '0;
        end else if (grant0) begin
            Resp0Valid  <= 1'b1;
            Resp0Result <= AluResult;
            Resp0Flags  <= alu_flags;
        end else if (Resp0Ready) begin
            Resp0Valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Resp1Valid  <= 1'b0;
            Resp1Result <= '0;
            Resp1Flags  <= '0;
        end else if (grant1) begin
            Resp1Valid  <= 1'b1;
            Resp1Result <= AluResult;
            Resp1Flags  <= alu_flags;
        end else if (Resp1Ready) begin
            Resp1Valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vectors, corner sequences and random traffic
// for alu_share_arbiter, with a behavioural ALU and slot model.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        Req0Valid, Req0Ready;
    logic [31:0] Req0SrcA, Req0SrcB;
    logic [3:0]  Req0Ctrl;
    logic        Req1Valid, Req1Ready;
    logic [31:0] Req1SrcA, Req1SrcB;
    logic [3:0]  Req1Ctrl;
    logic        Resp0Valid, Resp0Ready;
    logic [31:0] Resp0Result;
    logic [3:0]  Resp0Flags;
    logic        Resp1Valid, Resp1Ready;
    logic [31:0] Resp1Result;
    logic [3:0]  Resp1Flags;
    logic [31:0] AluSrcA, AluSrcB, AluResult;
    logic [3:0]  AluControl;
    logic        AluZero, AluN, AluC, AluV;
    logic        LastGrant;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready),
        .Req0SrcA(Req0SrcA), .Req0SrcB(Req0SrcB), .Req0Ctrl(Req0Ctrl),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready),
        .Req1SrcA(Req1SrcA), .Req1SrcB(Req1SrcB), .Req1Ctrl(Req1Ctrl),
        .Resp0Valid(Resp0Valid), .Resp0Ready(Resp0Ready),
        .Resp0Result(Resp0Result), .Resp0Flags(Resp0Flags),
        .Resp1Valid(Resp1Valid), .Resp1Ready(Resp1Ready),
        .Resp1Result(Resp1Result), .Resp1Flags(Resp1Flags),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluControl(AluControl),
        .AluResult(AluResult), .AluZero(AluZero), .AluN(AluN),
        .AluC(AluC), .AluV(AluV),
        .LastGrant(LastGrant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: add, sub (C = borrow), and, or, xor otherwise.
    function automatic void alu_eval(
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [3:0]  c,
        output logic [31:0] r,
        output logic [3:0]  f
    );
        logic [32:0] s;
        logic        cy, v;
        s  = '0;
        cy = 1'b0;
        v  = 1'b0;
        case (c)
            4'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cy = s[32];
                v  = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1:    begin r = a - b; cy = (a < b); end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            default: r = a ^ b;
        endcase
        f = {(r == 32'd0), r[31], cy, v};
    endfunction

    logic [31:0] env_r;
    logic [3:0]  env_f;
    always_comb begin
        env_r = '0;
        env_f = '0;
        alu_eval(AluSrcA, AluSrcB, AluControl, env_r, env_f);
    end
    assign AluResult = env_r;
    assign {AluZero, AluN, AluC, AluV} = env_f;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stimulus held in arrays so the model can read it by index.
    logic        iv [2];
    logic [31:0] ia [2];
    logic [31:0] ib [2];
    logic [3:0]  ic [2];
    logic        irr[2];

    task automatic apply();
        Req0Valid = iv[0]; Req0SrcA = ia[0];
        Req0SrcB = ib[0]; Req0Ctrl = ic[0];
        Req1Valid = iv[1]; Req1SrcA = ia[1];
        Req1SrcB = ib[1]; Req1Ctrl = ic[1];
        Resp0Ready = irr[0];
        Resp1Ready = irr[1];
    endtask

    // Model: each slot is {valid, result, flags}; m_lg is last winner.
    logic        m_v  [2];
    logic [31:0] m_res[2];
    logic [3:0]  m_fl [2];
    int          m_lg;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_res[i] = '0; m_fl[i] = '0;
        end
        m_lg = 1;
    endtask

    // Winner index, or -1 when nobody may go.
    function automatic int pick();
        int cand[$];
        for (int i = 0; i < 2; i++)
            if (iv[i] && (!m_v[i] || irr[i])) cand.push_back(i);
        if (cand.size() == 2) return 1 - m_lg;
        if (cand.size() == 1) return cand[0];
        return -1;
    endfunction

    task automatic model_update(input int g);
        for (int i = 0; i < 2; i++) begin
            if (g == i) begin
                m_v[i] = 1'b1;
                alu_eval(ia[i], ib[i], ic[i], m_res[i], m_fl[i]);
            end else if (irr[i]) begin
                m_v[i] = 1'b0;
            end
        end
        if (g >= 0) m_lg = g;
    endtask

    task automatic chk_model(input string t);
        chk({t, " r0v"}, Resp0Valid, m_v[0]);
        chk({t, " r0res"}, Resp0Result, m_res[0]);
        chk({t, " r0fl"}, Resp0Flags, m_fl[0]);
        chk({t, " r1v"}, Resp1Valid, m_v[1]);
        chk({t, " r1res"}, Resp1Result, m_res[1]);
        chk({t, " r1fl"}, Resp1Flags, m_fl[1]);
        chk({t, " lg"}, LastGrant, m_lg[0]);
    endtask

    typedef struct {
        logic v0; logic [31:0] a0, b0; logic [3:0] c0;
        logic v1; logic [31:0] a1, b1; logic [3:0] c1;
        logic rr0, rr1;
        logic rdy0, rdy1;
        logic q0v; logic [31:0] q0r; logic [3:0] q0f;
        logic q1v; logic [31:0] q1r; logic [3:0] q1f;
        logic lg;
    } vec_t;

    function automatic vec_t mk(
        logic v0, logic [31:0] a0, logic [31:0] b0, logic [3:0] c0,
        logic v1, logic [31:0] a1, logic [31:0] b1, logic [3:0] c1,
        logic rr0, logic rr1, logic rdy0, logic rdy1,
        logic q0v, logic [31:0] q0r, logic [3:0] q0f,
        logic q1v, logic [31:0] q1r, logic [3:0] q1f,
        logic lg
    );
        vec_t x;
        x.v0 = v0; x.a0 = a0; x.b0 = b0; x.c0 = c0;
        x.v1 = v1; x.a1 = a1; x.b1 = b1; x.c1 = c1;
        x.rr0 = rr0; x.rr1 = rr1; x.rdy0 = rdy0; x.rdy1 = rdy1;
        x.q0v = q0v; x.q0r = q0r; x.q0f = q0f;
        x.q1v = q1v; x.q1r = q1r; x.q1f = q1f;
        x.lg = lg;
        return x;
    endfunction

    vec_t vecs[17];

    initial begin
        string t;
        int    g;

        // add 5+7, then sub 3-3, then drain
        vecs[0]  = mk(1,5,7,0, 0,0,0,0, 1,1, 1,0, 1,12,0, 0,0,0, 0);
        vecs[1]  = mk(1,3,3,1, 0,0,0,0, 1,1, 1,0, 1,0,8,  0,0,0, 0);
        vecs[2]  = mk(0,0,0,0, 0,0,0,0, 1,1, 0,0, 0,0,8,  0,0,0, 0);
        // both requesting, both draining: strict alternation
        vecs[3]  = mk(1,1,1,0, 1,100,0,1, 1,1, 0,1, 0,0,8, 1,100,0, 1);
        vecs[4]  = mk(1,2,1,0, 1,100,1,1, 1,1, 1,0, 1,3,0, 0,100,0, 0);
        vecs[5]  = mk(1,3,1,0, 1,100,2,1, 1,1, 0,1, 0,3,0, 1,98,0,  1);
        vecs[6]  = mk(1,4,1,0, 1,100,3,1, 1,1, 1,0, 1,5,0, 0,98,0,  0);
        vecs[7]  = mk(1,5,1,0, 1,100,4,1, 1,1, 0,1, 0,5,0, 1,96,0,  1);
        vecs[8]  = mk(1,6,1,0, 1,100,5,1, 1,1, 1,0, 1,7,0, 0,96,0,  0);
        // drain+refill with carry-out wrap to zero
        vecs[9]  = mk(1,32'hFFFF_FFFF,1,0, 0,0,0,0, 1,1, 1,0,
                      1,0,4'hA, 0,96,0, 0);
        // slot 0 stalled: req1 wins every cycle, req0 fields wander
        vecs[10] = mk(1,9,9,0,  1,200,0,0, 0,1, 0,1, 1,0,4'hA, 1,200,0, 1);
        vecs[11] = mk(1,77,1,1, 1,200,1,0, 0,1, 0,1, 1,0,4'hA, 1,201,0, 1);
        vecs[12] = mk(1,123,5,2,1,200,2,0, 0,1, 0,1, 1,0,4'hA, 1,202,0, 1);
        vecs[13] = mk(1,9,9,0,  1,200,3,0, 0,1, 0,1, 1,0,4'hA, 1,203,0, 1);
        // slot 0 drains: req0 wins next
        vecs[14] = mk(1,9,9,0,  1,200,4,0, 1,1, 1,0, 1,18,0, 0,203,0, 0);
        vecs[15] = mk(0,0,0,0,  0,0,0,0,   1,1, 0,0, 0,18,0, 0,203,0, 0);
        // signed overflow on requester 1
        vecs[16] = mk(0,0,0,0, 1,32'h7FFF_FFFF,1,0, 1,1, 0,1,
                      0,18,0, 1,32'h8000_0000,4'h5, 1);

        // Reset held with a request pending: nothing accepted
        rst_n = 1'b0;
        iv[0] = 1; ia[0] = 5; ib[0] = 7; ic[0] = 1;
        iv[1] = 1; ia[1] = 3; ib[1] = 4; ic[1] = 1;
        irr[0] = 1; irr[1] = 1;
        apply();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst rdy0", Req0Ready, 0);
        chk("rst rdy1", Req1Ready, 0);
        chk("rst alua", AluSrcA, 0);
        chk("rst aluctl", AluControl, 0);
        chk_model("rst");
        rst_n = 1'b1;

        for (int k = 0; k < 17; k++) begin
            iv[0] = vecs[k].v0; ia[0] = vecs[k].a0;
            ib[0] = vecs[k].b0; ic[0] = vecs[k].c0;
            iv[1] = vecs[k].v1; ia[1] = vecs[k].a1;
            ib[1] = vecs[k].b1; ic[1] = vecs[k].c1;
            irr[0] = vecs[k].rr0; irr[1] = vecs[k].rr1;
            apply();
            #1;
            t = $sformatf("vec%0d", k);
            chk({t, " rdy0"}, Req0Ready, vecs[k].rdy0);
            chk({t, " rdy1"}, Req1Ready, vecs[k].rdy1);
            g = pick();
            @(posedge clk);
            model_update(g);
            @(negedge clk);
            chk({t, " r0v"}, Resp0Valid, vecs[k].q0v);
            chk({t, " r0res"}, Resp0Result, vecs[k].q0r);
            chk({t, " r0fl"}, Resp0Flags, vecs[k].q0f);
            chk({t, " r1v"}, Resp1Valid, vecs[k].q1v);
            chk({t, " r1res"}, Resp1Result, vecs[k].q1r);
            chk({t, " r1fl"}, Resp1Flags, vecs[k].q1f);
            chk({t, " lg"}, LastGrant, vecs[k].lg);
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                iv[i]  = ($urandom_range(0, 9) < 7);
                ic[i]  = 4'($urandom_range(0, 4));
                irr[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    ia[i] = 32'($urandom_range(0, 3));
                    ib[i] = 32'($urandom_range(0, 3));
                end else begin
                    ia[i] = $urandom;
                    ib[i] = $urandom;
                end
            end
            apply();
            #1;
            t = $sformatf("rnd%0d", n);
            g = pick();
            chk({t, " rdy0"}, Req0Ready, (g == 0));
            chk({t, " rdy1"}, Req1Ready, (g == 1));
            chk({t, " alua"}, AluSrcA, (g >= 0) ? ia[g] : 32'd0);
            chk({t, " alub"}, AluSrcB, (g >= 0) ? ib[g] : 32'd0);
            chk({t, " aluc"}, AluControl, (g >= 0) ? ic[g] : 4'd0);
            @(posedge clk);
            model_update(g);
            @(negedge clk);
            chk_model(t);
        end

        // Reset with a result in flight discards it
        iv[0] = 1; ia[0] = 40; ib[0] = 2; ic[0] = 0;
        iv[1] = 0; irr[0] = 0; irr[1] = 0;
        apply();
        @(negedge clk);
        @(negedge clk);
        chk("mid r0v pre", Resp0Valid, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid rdy0", Req0Ready, 0);
        chk("mid alua", AluSrcA, 0);
        chk_model("mid");
        @(negedge clk);
        chk("mid hold r0v", Resp0Valid, 0);
        chk("mid hold lg", LastGrant, 1);
        iv[0] = 0;
        apply();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post r0v", Resp0Valid, 0);
        chk("post r0res", Resp0Result, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
